bcd_uart_tx: RTL and testbench

//  Downstream of the binary-to-BCD stage: takes a two-digit BCD value (tens, ones), converts each

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_byte.sv | 95 +++++++++
 rtl/bcd_uart_tx.sv | 91 +++++++++
 tb/tb_bcd_uart_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the BCD-to-UART text path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_state_t;
  typedef enum logic [1:0] {M_IDLE, M_SEND, M_DONE} msg_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Non-decimal codes (10..15) print as '?' so a corrupt digit is visible on the terminal.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    if (d <= 4'd9) return ASCII_ZERO + {4'b0000, d};
    else           return ASCII_QMARK;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART 8N1 serializer: start bit, 8 data bits LSB first, stop bit.
// Latency: tx falls on the edge that accepts send; each bit lasts CLKS_PER_BIT cycles.
// Backpressure: ready is high in IDLE and in the last stop-bit cycle, so frames chain with no gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       send,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  byte_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          baud_tc;

  assign baud_tc = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  // Accepting in the final stop cycle lets the next start bit follow directly.
  assign ready   = (state == IDLE) || ((state == STOP) && baud_tc);

  // Bit sequencer; tx is registered so the line never glitches.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (send) begin
            state <= START;
            shreg <= data;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
              tx      <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (send) begin
              state <= START;
              shreg <= data;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/bcd_uart_tx.sv
// Prints a two-digit BCD value as ASCII over UART 8N1 (optional CR/LF with BCD_UART_CRLF_EN).
// Latency: tx falls one edge after start is accepted; done pulses N*10*CLKS_PER_BIT cycles later.
// Backpressure: none; start is only accepted while busy is low, requests during a message are dropped.
module bcd_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic       tx
);

`ifdef BCD_UART_CRLF_EN
  localparam logic [2:0] NCHARS = 3'd4;
`else
  localparam logic [2:0] NCHARS = 3'd2;
`endif

  msg_state_t mstate;
  logic [2:0] char_idx;   // next char to hand off; NCHARS means all handed off
  logic [3:0] tens_q;
  logic [3:0] ones_q;
  logic [7:0] char_dat;
  logic       send;
  logic       ready;

  assign busy = (mstate == M_SEND);
  assign done = (mstate == M_DONE);
  assign send = (mstate == M_SEND) && (char_idx < NCHARS);

  // Character select for the current position in the message.
  always_comb begin
    char_dat = ASCII_LF;
    case (char_idx[1:0])
      2'd0:    char_dat = bcd_to_ascii(tens_q);
      2'd1:    char_dat = bcd_to_ascii(ones_q);
      2'd2:    char_dat = ASCII_CR;
      default: char_dat = ASCII_LF;
    endcase
  end

  // Message sequencer; DONE also accepts start so a held request restarts immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mstate   <= M_IDLE;
      char_idx <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
    end else begin
      case (mstate)
        M_IDLE, M_DONE: begin
          if (start) begin
            mstate   <= M_SEND;
            char_idx <= '0;
            tens_q   <= tens;
            ones_q   <= ones;
          end else begin
            mstate <= M_IDLE;
          end
        end
        M_SEND: begin
          if (send && ready) begin
            char_idx <= char_idx + 3'd1;
          end else if ((char_idx == NCHARS) && ready) begin
            // ready here means the last stop bit has just finished.
            mstate <= M_DONE;
          end
        end
        default: mstate <= M_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk  (clk),
    .n_rst(n_rst),
    .send (send),
    .data (char_dat),
    .tx   (tx),
    .ready(ready)
  );

endmodule

// File: tb/tb_bcd_uart_tx.sv
// Directed bench for bcd_uart_tx with CLKS_PER_BIT=4 and a mid-bit UART monitor.
// Build with BCD_UART_CRLF_EN defined to exercise the four-character message.
// Outputs are sampled on the falling clock edge.
module tb_bcd_uart_tx;

  localparam int CPB = 4;
`ifdef BCD_UART_CRLF_EN
  localparam int N = 4;
`else
  localparam int N = 2;
`endif
  localparam int MSG_CYC = N * 10 * CPB;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;
  logic       busy, done, tx;

  int         nvec = 0;
  int         nerr = 0;
  int         cyc = 0;
  int         fall = 0;
  logic [7:0] rxq[$];

  bcd_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .start(start),
    .tens (tens),
    .ones (ones),
    .busy (busy),
    .done (done),
    .tx   (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // UART receiver: detect start bit, then sample every bit near its middle.
  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1 && tx === 1'b0) begin
        repeat (CPB / 2 - 1) @(negedge clk);
        chk("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        chk("stop_bit", {31'd0, tx}, 32'd1);
        rxq.push_back(b);
      end
    end
  end

  task automatic expect_fall();
    @(negedge clk);
    chk("tx_fall", {31'd0, tx}, 32'd0);
    fall = cyc;
  endtask

  // Request a message; start stays high when hold=1.
  task automatic send_msg(input logic [3:0] t, input logic [3:0] o, input bit hold);
    rxq.delete();
    @(negedge clk);
    tens  = t;
    ones  = o;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("busy_acc", {31'd0, busy}, 32'd1);
    chk("tx_acc", {31'd0, tx}, 32'd1);
    expect_fall();
  endtask

  task automatic finish_msg(input logic [7:0] e0, input logic [7:0] e1, input bit busy_after);
    logic [7:0] exp_b[4];
    bit got;
    exp_b[0] = e0;
    exp_b[1] = e1;
    exp_b[2] = 8'h0D;
    exp_b[3] = 8'h0A;
    got = 0;
    for (int i = 0; i < MSG_CYC + 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("done_lat", cyc - fall, MSG_CYC);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    chk("nbytes", rxq.size(), N);
    for (int i = 0; i < N; i++) begin
      if (i < rxq.size()) chk($sformatf("byte%0d", i), {24'd0, rxq[i]}, {24'd0, exp_b[i]});
    end
    @(negedge clk);
    chk("done_width", {31'd0, done}, 32'd0);
    chk("busy_after", {31'd0, busy}, {31'd0, busy_after});
    rxq.delete();
  endtask

  initial begin : stim
    int dcnt;
    int bad_tx;
    int bad_busy;
    int bad_done;

    // Reset values
    #3 n_rst = 1'b0;
    #4;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    // 1: "42"
    send_msg(4'd4, 4'd2, 0);
    finish_msg(8'h34, 8'h32, 0);

    // 2: no leading-zero blanking
    send_msg(4'd0, 4'd0, 0);
    finish_msg(8'h30, 8'h30, 0);

    // 3: invalid BCD tens digit
    send_msg(4'd12, 4'd9, 0);
    finish_msg(8'h3F, 8'h39, 0);

    // 4a: request during char 1 is dropped; latched digits are kept
    send_msg(4'd4, 4'd2, 0);
    repeat (50) @(negedge clk);
    tens  = 4'd1;
    ones  = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_drop", {31'd0, busy}, 32'd1);
    finish_msg(8'h34, 8'h32, 0);

    // 4b: start held high restarts on the DONE edge
    send_msg(4'd5, 4'd6, 1);
    tens = 4'd7;
    ones = 4'd8;
    finish_msg(8'h35, 8'h36, 1);
    chk("restart_tx_idle", {31'd0, tx}, 32'd1);
    start = 1'b0;
    expect_fall();
    finish_msg(8'h37, 8'h38, 0);

    // 5: async reset during char 0 data bits aborts without done
    send_msg(4'd4, 4'd2, 0);
    repeat (4 * CPB) @(negedge clk);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) dcnt++;
    end
    n_rst = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done !== 1'b0) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    send_msg(4'd0, 4'd7, 0);
    finish_msg(8'h30, 8'h37, 0);

    // 6: quiet line while idle
    bad_tx = 0;
    bad_busy = 0;
    bad_done = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (done !== 1'b0) bad_done++;
    end
    chk("idle_tx", bad_tx, 0);
    chk("idle_busy", bad_busy, 0);
    chk("idle_done", bad_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
